// File: rtl/alu_op_sequencer_pkg.sv
// Shared encodings for the ALU op sequencer: request groups, opcodes and FSM states.
package alu_op_sequencer_pkg;

    // Request group selector carried on req_aluop.
    localparam logic [1:0] ALUOP_ARITH = 2'b01;
    localparam logic [1:0] ALUOP_CMP   = 2'b10;

    // Operations within the arithmetic/logic group.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NEG = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    // Operations within the compare group. Other codes yield zero.
    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_GT  = 3'b001;
    localparam logic [2:0] CMP_LEQ = 3'b010;

    // Sequencer states: wait for request, single-step op, multiply loop, hold result.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MUL  = 2'b10,
        DONE = 2'b11
    } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_adder.sv
// The one WIDTH-bit adder shared by every operation of the sequencer.
module alu_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Full add with carry-out; signed overflow when both inputs share a sign the sum does not.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        ovf         = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU front end: one request at a time, single shared adder,
// shift-add multiply, result held until the consumer takes it.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [2:0]       req_opcode2,
    input  logic [WIDTH-1:0] req_op1,
    input  logic [WIDTH-1:0] req_op2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    seq_state_e       state_q, state_d;
    logic [1:0]       aluop_q;
    logic [2:0]       opcode_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] addA, addB, addSum;
    logic             addCin, addOvf, unusedCout;
    logic [WIDTH-1:0] execResult;
    logic             isMulReq, lastIter, lt, eq;

    assign isMulReq = (req_aluop == ALUOP_ARITH) && (req_opcode2 == OP_MUL);
    assign lastIter = (cnt_q == LAST_ITER);
    assign lt       = addSum[WIDTH-1] ^ addOvf;
    assign eq       = (op1_q == op2_q);
    assign resp_result = result_q;

    alu_adder #(.WIDTH(WIDTH)) u_adder (
        .a   (addA),
        .b   (addB),
        .cin (addCin),
        .sum (addSum),
        .cout(unusedCout),
        .ovf (addOvf)
    );

    // State register; reset abandons any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: multiply takes the loop path, everything else one step; DONE waits for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = isMulReq ? MUL : EXEC;
            EXEC:    state_d = DONE;
            MUL:     if (lastIter) state_d = DONE;
            DONE:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded purely from the state.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE:      req_ready  = 1'b1;
            EXEC, MUL: busy       = 1'b1;
            DONE:      resp_valid = 1'b1;
            default:   ;
        endcase
    end

    // Adder input mux: accumulate during multiply, subtract for sub and compares, plain add otherwise.
    always_comb begin
        addA   = op1_q;
        addB   = op2_q;
        addCin = 1'b0;
        if (state_q == MUL) begin
            addA = acc_q;
            addB = op1_q;
        end else if ((aluop_q == ALUOP_CMP) ||
                     ((aluop_q == ALUOP_ARITH) && (opcode_q == OP_SUB))) begin
            addB   = ~op2_q;
            addCin = 1'b1;
        end
    end

    // Single-step result selection; compares use the overflow-corrected sign of op1-op2.
    always_comb begin
        execResult = '0;
        case (aluop_q)
            ALUOP_ARITH: begin
                case (opcode_q)
                    OP_ADD, OP_SUB: execResult = addSum;
                    OP_NEG:         execResult = ~op1_q;
                    OP_AND:         execResult = op1_q & op2_q;
                    OP_OR:          execResult = op1_q | op2_q;
                    OP_XOR:         execResult = op1_q ^ op2_q;
                    OP_NOT:         execResult = {{(WIDTH-1){1'b0}}, (op1_q == '0)};
                    default:        execResult = '0;
                endcase
            end
            ALUOP_CMP: begin
                case (opcode_q)
                    CMP_EQ:  execResult = {{(WIDTH-1){1'b0}}, eq};
                    CMP_GT:  execResult = {{(WIDTH-1){1'b0}}, (!lt && !eq)};
                    CMP_LEQ: execResult = {{(WIDTH-1){1'b0}}, (lt || eq)};
                    default: execResult = '0;
                endcase
            end
            default: execResult = '0;
        endcase
    end

    // Datapath: capture on accept, shift-add each MUL cycle, load the result only when entering DONE.
    // The loop exits on the cycle that would take the counter to WIDTH, so MUL lasts exactly WIDTH cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluop_q  <= '0;
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        aluop_q  <= req_aluop;
                        opcode_q <= req_opcode2;
                        op1_q    <= req_op1;
                        op2_q    <= req_op2;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                EXEC: result_q <= execResult;
                MUL: begin
                    if (op2_q[0]) acc_q <= addSum;
                    op1_q <= op1_q << 1;
                    op2_q <= op2_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (lastIter) result_q <= op2_q[0] ? addSum : acc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a driver pushes expected results from a
// behavioural model, a monitor pops and compares whenever a response appears.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_aluop = '0;
    logic [2:0]   req_opcode2 = '0;
    logic [W-1:0] req_op1 = '0;
    logic [W-1:0] req_op2 = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] resp_result;
    logic         busy;

    typedef struct {
        logic [W-1:0] result;
        int           latency;
        int           busyCycles;
        int           acceptEdge;
    } exp_t;

    exp_t         expQ[$];
    exp_t         cur;
    int           assertCount = 0;
    int           failCount = 0;
    int           cycleCount = 0;
    int           respMode = 0;
    int           busyRun = 0;
    logic         prevValid = 1'b0;

    alu_op_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_aluop  (req_aluop),
        .req_opcode2(req_opcode2),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result),
        .busy       (busy)
    );

    // Free-running clock and an edge counter used to measure latency.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Consumer: always ready, randomly stalling, or held off entirely.
    always @(negedge clk) begin
        case (respMode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ($urandom_range(0, 2) != 0);
            default: resp_ready = 1'b0;
        endcase
    end

    // Behavioural reference: the operation as plain arithmetic on the operands.
    function automatic logic [W-1:0] refModel(input logic [1:0] grp, input logic [2:0] opc,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        if (grp == 2'b01) begin
            case (opc)
                3'd0: r = a + b;
                3'd1: r = a - b;
                3'd2: r = ~a;
                3'd3: r = a * b;
                3'd4: r = a & b;
                3'd5: r = a | b;
                3'd6: r = a ^ b;
                default: r = (a == 0) ? 1 : 0;
            endcase
        end else if (grp == 2'b10) begin
            case (opc)
                3'd0: r = (a == b) ? 1 : 0;
                3'd1: r = ($signed(a) > $signed(b)) ? 1 : 0;
                3'd2: r = ($signed(a) <= $signed(b)) ? 1 : 0;
                default: r = 0;
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%h required=%h at cycle %0d", name, actual, expected, cycleCount);
        end
    endtask

    // Drive one request, wait (bounded) for acceptance, and push its expected response.
    task automatic applyStimulus(input logic [1:0] grp, input logic [2:0] opc,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        int   waitCycles;
        exp_t e;
        bit   isMul;
        waitCycles = 0;
        @(negedge clk);
        req_valid   = 1'b1;
        req_aluop   = grp;
        req_opcode2 = opc;
        req_op1     = a;
        req_op2     = b;
        while (!req_ready && waitCycles < 300) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        isMul        = (grp == 2'b01) && (opc == 3'd3);
        e.result     = refModel(grp, opc, a, b);
        e.latency    = isMul ? W + 1 : 2;
        e.busyCycles = isMul ? W : 1;
        e.acceptEdge = cycleCount;
        expQ.push_back(e);
        req_valid   = 1'b0;
        req_op1     = $urandom;
        req_op2     = $urandom;
    endtask

    task automatic waitDrain(input string name);
        int guard;
        guard = 0;
        while ((expQ.size() != 0 || resp_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(name, expQ.size(), 0);
    endtask

    // Monitor: on each new response pop the scoreboard, check value, latency and busy time;
    // while a response is held, check it stays put and no new request can be taken.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            busyRun   = 0;
            prevValid = 1'b0;
        end else begin
            if (busy) busyRun++;
            if (resp_valid) begin
                checkOutput("req_ready_low_while_resp", req_ready, 0);
                if (!prevValid) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_resp", 1, 0);
                        cur.result = resp_result;
                    end else begin
                        cur = expQ.pop_front();
                        checkOutput("result", resp_result, cur.result);
                        checkOutput("latency", cycleCount + 1 - cur.acceptEdge, cur.latency);
                        checkOutput("busy_cycles", busyRun, cur.busyCycles);
                    end
                    busyRun = 0;
                end else begin
                    checkOutput("result_held", resp_result, cur.result);
                end
            end
            prevValid = resp_valid;
        end
    end

    initial begin
        logic [1:0]   ag;
        logic [2:0]   oc;
        logic [W-1:0] a, b;
        int           pick;

        // Reset values while held in reset, then readiness after release.
        repeat (2) @(negedge clk);
        checkOutput("reset_resp_valid", resp_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_result", resp_result, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_req_ready", req_ready, 1);

        // Directed arithmetic, logic, multiply and compare cases.
        applyStimulus(ALUOP_ARITH, OP_ADD, 32'd5, 32'd7);
        applyStimulus(ALUOP_ARITH, OP_SUB, 32'd3, 32'd5);
        applyStimulus(ALUOP_ARITH, OP_NEG, 32'h0000000F, 32'd0);
        applyStimulus(ALUOP_ARITH, OP_NOT, 32'd0, 32'd0);
        applyStimulus(ALUOP_ARITH, OP_NOT, 32'd9, 32'd0);
        applyStimulus(ALUOP_ARITH, OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
        applyStimulus(ALUOP_ARITH, OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000);
        applyStimulus(ALUOP_ARITH, OP_MUL, 32'h0001_0003, 32'd5);
        applyStimulus(ALUOP_ARITH, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(ALUOP_CMP, CMP_GT, 32'hFFFF_FFFF, 32'd1);
        applyStimulus(ALUOP_CMP, CMP_LEQ, 32'hFFFF_FFFF, 32'd1);
        applyStimulus(ALUOP_CMP, CMP_GT, 32'h7FFF_FFFF, 32'h8000_0000);
        applyStimulus(ALUOP_CMP, CMP_LEQ, 32'h8000_0000, 32'h7FFF_FFFF);
        applyStimulus(ALUOP_CMP, CMP_EQ, 32'd7, 32'd7);
        applyStimulus(ALUOP_CMP, 3'b111, 32'd7, 32'd7);
        applyStimulus(2'b00, OP_ADD, 32'd1, 32'd2);
        applyStimulus(2'b11, OP_OR, 32'd1, 32'd2);
        waitDrain("drain_directed");

        // Backpressure: consumer stalls while a second request waits on req_valid.
        respMode = 2;
        applyStimulus(ALUOP_ARITH, OP_ADD, 32'd100, 32'd23);
        fork
            applyStimulus(ALUOP_ARITH, OP_SUB, 32'd10, 32'd20);
            begin
                int guard;
                guard = 0;
                while (!resp_valid && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                checkOutput("bp_resp_seen", resp_valid, 1);
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("bp_req_ready_low", req_ready, 0);
                end
                respMode = 0;
            end
        join
        waitDrain("drain_backpressure");

        // Randomized operations with a randomly stalling consumer.
        respMode = 1;
        for (int i = 0; i < 60; i++) begin
            pick = $urandom_range(0, 9);
            if (pick < 5)      ag = ALUOP_ARITH;
            else if (pick < 9) ag = ALUOP_CMP;
            else               ag = 2'($urandom_range(0, 3));
            oc = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 2) == 0) a = W'($urandom_range(0, 15));
            applyStimulus(ag, oc, a, b);
        end
        respMode = 0;
        waitDrain("drain_random");

        // Reset in the middle of a multiply: outputs clear at once and no response follows.
        applyStimulus(ALUOP_ARITH, OP_MUL, 32'h1234_5678, 32'h9ABC_DEF1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_resp_valid", resp_valid, 0);
        checkOutput("midreset_result", resp_result, 0);
        expQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("postreset_req_ready", req_ready, 1);
        applyStimulus(ALUOP_ARITH, OP_ADD, 32'd1, 32'd1);
        waitDrain("drain_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
